sweep_checker: RTL

SWEEP_CHECKER -- requirements
Module: sweep_checker

---
 rtl/sweep_pkg.sv | 16 +
 rtl/sweep_cnt.sv | 43 ++++
 rtl/sweep_checker.sv | 96 +++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types for the exhaustive input-sweep checker: FSM state encoding
// and the counter-width helper used to size the settle counter.
package sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Width needed to count 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sweep_cnt.sv
// Combined settle/vector counter: holds each vector for SETTLE_CYC cycles
// and flags the edge that ends each hold plus the final vector of a sweep.
module sweep_cnt
  import sweep_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  input  logic            run,
  output logic [N_IN-1:0] vec,
  output logic            sample,
  output logic            last
);

  localparam int HW = cnt_width(SETTLE_CYC);

  logic [HW-1:0] hold;

  assign sample = run && (hold == HW'(SETTLE_CYC - 1));
  assign last   = (vec == '1);

  // The vector index wraps naturally to 0 after the final sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= '0;
      vec  <= '0;
    end else if (clear) begin
      hold <= '0;
      vec  <= '0;
    end else if (run) begin
      if (sample) begin
        hold <= '0;
        vec  <= vec + 1'b1;
      end else begin
        hold <= hold + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sweep_checker.sv
// Walks every input vector of a small combinational circuit, compares the
// response with an expected truth table and reports error count and first failure.
module sweep_checker
  import sweep_pkg::*;
#(
  parameter int                N_IN       = 4,
  parameter int                SETTLE_CYC = 1,
  parameter logic [2**N_IN-1:0] EXP_TABLE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            dut_i,
  output logic [N_IN-1:0] vec_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic            fail_vld,
  output logic [N_IN-1:0] fail_idx
);

  state_t state, state_nxt;
  logic   sample, last, mismatch, cnt_clear, cnt_run;

  assign cnt_run   = (state == SWEEP);
  assign cnt_clear = (state != SWEEP) || abort;

  sweep_cnt #(
    .N_IN      (N_IN),
    .SETTLE_CYC(SETTLE_CYC)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .run   (cnt_run),
    .vec   (vec_o),
    .sample(sample),
    .last  (last)
  );

  assign mismatch = sample && (dut_i != EXP_TABLE[vec_o]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Abort beats start in IDLE and pre-empts sampling in SWEEP.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start && !abort) state_nxt = SWEEP;
      SWEEP: begin
        busy = 1'b1;
        if (abort)              state_nxt = IDLE;
        else if (sample && last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Results are frozen outside SWEEP so an aborted run keeps its partial counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_idx <= '0;
      pass     <= 1'b0;
    end else begin
      if (state == IDLE && start && !abort) begin
        err_cnt  <= '0;
        fail_vld <= 1'b0;
        fail_idx <= '0;
        pass     <= 1'b0;
      end else if (state == SWEEP && !abort && sample) begin
        if (mismatch) begin
          err_cnt <= err_cnt + 1'b1;
          if (!fail_vld) begin
            fail_vld <= 1'b1;
            fail_idx <= vec_o;
          end
        end
        if (last) pass <= (err_cnt == '0) && !mismatch;
      end
    end
  end

endmodule
